// File: rtl/ex_div_unit_if.sv
// Handshake/operand bundle between the EX stage and the iterative divider.
// DIV_STATUS_EN adds the div_zero status output.
interface ex_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
`ifdef DIV_STATUS_EN
  logic            div_zero;

  modport master (
    output start, op, data1, data2, flush,
    input  busy, done, result, div_zero
  );
  modport slave (
    input  start, op, data1, data2, flush,
    output busy, done, result, div_zero
  );
`else
  modport master (
    output start, op, data1, data2, flush,
    input  busy, done, result
  );
  modport slave (
    input  start, op, data1, data2, flush,
    output busy, done, result
  );
`endif
endinterface

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_STATUS_EN adds the div_zero status output.
module ex_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  ex_div_unit_if.slave  div_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_q, neg_d;
  logic            spec_q, spec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef DIV_STATUS_EN
  logic            dz_q, dz_d;
`endif

  logic            signed_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, overflow;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            fits;
  logic [XLEN-1:0] fin_val, fin_res;

  assign signed_op   = ~div_if.op[0];
  assign a_neg       = signed_op & div_if.data1[XLEN-1];
  assign b_neg       = signed_op & div_if.data2[XLEN-1];
  assign a_mag       = a_neg ? (~div_if.data1 + 1'b1) : div_if.data1;
  assign b_mag       = b_neg ? (~div_if.data2 + 1'b1) : div_if.data2;
  assign div_by_zero = (div_if.data2 == '0);
  assign overflow    = signed_op & (div_if.data1 == MIN_NEG) & (div_if.data2 == '1);

  // Borrow out of the (XLEN+1)-bit trial subtraction means rem_sh < divisor.
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};
  assign fits     = ~rem_diff[XLEN];

  assign fin_val = is_rem_q ? rem_q : quo_q;
  assign fin_res = neg_q ? (~fin_val + 1'b1) : fin_val;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    is_rem_d = is_rem_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef DIV_STATUS_EN
    dz_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (div_if.start && !div_if.flush) begin
          busy_d   = 1'b1;
          is_rem_d = div_if.op[1];
          dvs_d    = b_mag;
          cnt_d    = '0;
          // Special cases preload quo/rem with the final answer and skip CALC.
          if (div_by_zero) begin
            quo_d   = '1;
            rem_d   = div_if.data1;
            neg_d   = 1'b0;
            spec_d  = 1'b1;
            state_d = S_FIN;
          end else if (overflow) begin
            quo_d   = MIN_NEG;
            rem_d   = '0;
            neg_d   = 1'b0;
            spec_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            neg_d   = div_if.op[1] ? a_neg : (a_neg ^ b_neg);
            spec_d  = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (div_if.flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          rem_d = fits ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], fits};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (div_if.flush) begin
          busy_d  = 1'b0;
          spec_d  = 1'b0;
          state_d = S_IDLE;
        end else if (spec_q) begin
          // Special results wait one extra cycle so DONE lands at N+2.
          spec_d = 1'b0;
        end else begin
          result_d = fin_res;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
`ifdef DIV_STATUS_EN
          dz_d     = (dvs_q == '0);
`endif
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DIV_STATUS_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      is_rem_q <= is_rem_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DIV_STATUS_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign div_if.busy   = busy_q;
  assign div_if.done   = done_q;
  assign div_if.result = result_q;
`ifdef DIV_STATUS_EN
  assign div_if.div_zero = dz_q;
`endif

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed vector table, randomized ops
// against an arithmetic reference, and flush/reset/restart sequences.
module tb_ex_div_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ex_div_unit_if #(.XLEN(32)) dif ();

  ex_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .div_if  (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 33;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.start = 1'b1;
    dif.op    = op;
    dif.data1 = a;
    dif.data2 = b;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat, output logic [31:0] res,
                           output logic dz);
    lat = 0;
    res = 32'hDEAD_BEEF;
    dz  = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (dif.done) begin
        lat = i;
        res = dif.result;
`ifdef DIV_STATUS_EN
        dz  = dif.div_zero;
`endif
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (dif.done) cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input logic exp_dz);
    int lat;
    logic [31:0] res;
    logic dz;
    launch(op, a, b);
    check({tag, "_busy_accept"}, 32'(dif.busy), 32'd1);
    wait_done(60, lat, res, dz);
    check({tag, "_result"}, res, exp_res);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(dif.busy), 32'd0);
`ifdef DIV_STATUS_EN
    check({tag, "_div_zero"}, 32'(dz), 32'(exp_dz));
`else
    if (exp_dz && dz) $display("note: unexpected dz");
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(dif.done), 32'd0);
    check({tag, "_result_hold"}, dif.result, exp_res);
  endtask

  initial begin
    int lat, cnt;
    logic [31:0] res, prev;
    logic dz;
    logic [1:0] op;
    logic [31:0] a, b;

    dif.start = 1'b0;
    dif.op    = 2'b00;
    dif.data1 = '0;
    dif.data2 = '0;
    dif.flush = 1'b0;

    vecs.push_back('{2'b01, 32'd100,       32'd7,         32'd14,        33, 1'b0});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'd1,         33, 1'b0});
    vecs.push_back('{2'b00, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 2,  1'b1});
    vecs.push_back('{2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 2,  1'b1});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  1'b0});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  1'b0});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 1'b0});
    vecs.push_back('{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0});
    vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 1'b0});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'd3,         32'hD555_5556, 33, 1'b0});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 33, 1'b0});

    #23;
    check("reset_busy", 32'(dif.busy), 32'd0);
    check("reset_done", 32'(dif.done), 32'd0);
    check("reset_result", dif.result, 32'd0);
`ifdef DIV_STATUS_EN
    check("reset_div_zero", 32'(dif.div_zero), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_lat, vecs[i].exp_dz);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, ref_div(op, a, b), ref_lat(op, a, b), b == 32'd0);
    end

    // Flush ten cycles into CALC.
    prev = dif.result;
    launch(2'b01, 32'hFFFF_FFFF, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    dif.flush = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    check("flush_busy", 32'(dif.busy), 32'd0);
    check("flush_done", 32'(dif.done), 32'd0);
    check("flush_result_kept", dif.result, prev);
    count_done(40, cnt);
    check("flush_no_done", 32'(cnt), 32'd0);
    run_op("after_flush", 2'b01, 32'd1000, 32'd10, 32'd100, 33, 1'b0);

    // FLUSH together with START in IDLE starts nothing.
    @(negedge clk);
    dif.flush = 1'b1;
    dif.start = 1'b1;
    dif.op = 2'b01; dif.data1 = 32'd9; dif.data2 = 32'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.flush = 1'b0;
    check("flush_start_busy", 32'(dif.busy), 32'd0);
    count_done(40, cnt);
    check("flush_start_no_done", 32'(cnt), 32'd0);

    // Second START mid-CALC is ignored; operands changing after accept too.
    launch(2'b01, 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    dif.start = 1'b1;
    dif.op = 2'b00; dif.data1 = 32'd1000; dif.data2 = 32'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_done(60, lat, res, dz);
    check("midstart_result", res, 32'd14);
    check("midstart_latency", 32'(lat + 6), 32'd33);

    // START in the DONE cycle is accepted.
    launch(2'b01, 32'd50, 32'd5);
    wait_done(60, lat, res, dz);
    check("b2b_first", res, 32'd10);
    dif.start = 1'b1;
    dif.op = 2'b11; dif.data1 = 32'd50; dif.data2 = 32'd7;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    check("b2b_busy", 32'(dif.busy), 32'd1);
    wait_done(60, lat, res, dz);
    check("b2b_second", res, 32'd1);
    check("b2b_latency", 32'(lat), 32'd33);

    // Asynchronous reset mid-CALC.
    launch(2'b00, 32'hFFFF_FF9C, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(dif.busy), 32'd0);
    check("arst_done", 32'(dif.done), 32'd0);
    check("arst_result", dif.result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    count_done(40, cnt);
    check("arst_no_done", 32'(cnt), 32'd0);
    run_op("after_reset", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
